// File: rtl/bus_arbiter.sv
// Two-requester round-robin arbiter sharing one downstream bus port between
// instruction fetch and data memory, with one transaction outstanding at a time.
module bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                fetch_request_enable,
    input  logic                freq_mode,
    input  logic [ADDR_W-1:0]   freq_addr,
    input  logic [DATA_W-1:0]   freq_wdata,
    input  logic [DATA_W/8-1:0] freq_wstrb,
    output logic                fetch_response_enable,
    output logic [DATA_W-1:0]   fresp_data,

    input  logic                mem_request_enable,
    input  logic                mreq_mode,
    input  logic [ADDR_W-1:0]   mreq_addr,
    input  logic [DATA_W-1:0]   mreq_wdata,
    input  logic [DATA_W/8-1:0] mreq_wstrb,
    output logic                mem_response_enable,
    output logic [DATA_W-1:0]   mresp_data,

    output logic                bus_request_enable,
    output logic                breq_mode,
    output logic [ADDR_W-1:0]   breq_addr,
    output logic [DATA_W-1:0]   breq_wdata,
    output logic [DATA_W/8-1:0] breq_wstrb,
    input  logic                bus_response_enable,
    input  logic [DATA_W-1:0]   bresp_data,

    output logic                busy,
    output logic                grant_owner,
    output logic                protocol_err
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic {IDLE, WAIT} state_t;

    typedef struct packed {
        logic              mode;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } req_t;

    state_t state;
    logic   last_grant;
    logic   fetch_pend, mem_pend;
    req_t   fetch_slot, mem_slot;
    req_t   fetch_in, mem_in, win_req;
    logic   fetch_drop, mem_drop, fetch_take, mem_take;
    logic   fetch_cand, mem_cand, grant_now, winner;

    assign fetch_in = {freq_mode, freq_addr, freq_wdata, freq_wstrb};
    assign mem_in   = {mreq_mode, mreq_addr, mreq_wdata, mreq_wstrb};

    // A pulse from a requester that already has a pending slot or owns the
    // outstanding transaction is dropped; a fresh pulse can bypass its slot.
    always_comb begin
        fetch_drop = fetch_request_enable &&
                     (fetch_pend || (state == WAIT && grant_owner == 1'b0));
        mem_drop   = mem_request_enable &&
                     (mem_pend || (state == WAIT && grant_owner == 1'b1));
        fetch_take = fetch_request_enable && !fetch_drop;
        mem_take   = mem_request_enable && !mem_drop;
        fetch_cand = fetch_pend || fetch_take;
        mem_cand   = mem_pend || mem_take;
        grant_now  = (state == IDLE) && (fetch_cand || mem_cand);
        winner     = (fetch_cand && mem_cand) ? ~last_grant : mem_cand;
        if (winner)
            win_req = mem_pend ? mem_slot : mem_in;
        else
            win_req = fetch_pend ? fetch_slot : fetch_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                 <= IDLE;
            last_grant            <= 1'b1;
            fetch_pend            <= 1'b0;
            mem_pend              <= 1'b0;
            fetch_slot            <= '0;
            mem_slot              <= '0;
            bus_request_enable    <= 1'b0;
            breq_mode             <= 1'b0;
            breq_addr             <= '0;
            breq_wdata            <= '0;
            breq_wstrb            <= '0;
            fetch_response_enable <= 1'b0;
            mem_response_enable   <= 1'b0;
            fresp_data            <= '0;
            mresp_data            <= '0;
            busy                  <= 1'b0;
            grant_owner           <= 1'b0;
            protocol_err          <= 1'b0;
        end else begin
            bus_request_enable    <= 1'b0;
            fetch_response_enable <= 1'b0;
            mem_response_enable   <= 1'b0;

            if (fetch_drop || mem_drop || (state == IDLE && bus_response_enable))
                protocol_err <= 1'b1;

            if (grant_now && !winner) begin
                fetch_pend <= 1'b0;
            end else if (fetch_take) begin
                fetch_pend <= 1'b1;
                fetch_slot <= fetch_in;
            end

            if (grant_now && winner) begin
                mem_pend <= 1'b0;
            end else if (mem_take) begin
                mem_pend <= 1'b1;
                mem_slot <= mem_in;
            end

            case (state)
                IDLE: begin
                    if (grant_now) begin
                        bus_request_enable <= 1'b1;
                        {breq_mode, breq_addr, breq_wdata, breq_wstrb} <= win_req;
                        grant_owner        <= winner;
                        last_grant         <= winner;
                        busy               <= 1'b1;
                        state              <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus_response_enable) begin
                        if (grant_owner) begin
                            mem_response_enable <= 1'b1;
                            mresp_data          <= bresp_data;
                        end else begin
                            fetch_response_enable <= 1'b1;
                            fresp_data            <= bresp_data;
                        end
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus random traffic,
// every cycle compared against a slot/queue-level reference model.
module tb_bus_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;
    localparam int REQ_W  = 1 + ADDR_W + DATA_W + STRB_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              fetch_request_enable, freq_mode;
    logic [ADDR_W-1:0] freq_addr;
    logic [DATA_W-1:0] freq_wdata;
    logic [STRB_W-1:0] freq_wstrb;
    logic              fetch_response_enable;
    logic [DATA_W-1:0] fresp_data;
    logic              mem_request_enable, mreq_mode;
    logic [ADDR_W-1:0] mreq_addr;
    logic [DATA_W-1:0] mreq_wdata;
    logic [STRB_W-1:0] mreq_wstrb;
    logic              mem_response_enable;
    logic [DATA_W-1:0] mresp_data;
    logic              bus_request_enable, breq_mode;
    logic [ADDR_W-1:0] breq_addr;
    logic [DATA_W-1:0] breq_wdata;
    logic [STRB_W-1:0] breq_wstrb;
    logic              bus_response_enable;
    logic [DATA_W-1:0] bresp_data;
    logic              busy, grant_owner, protocol_err;

    always #5 clk = ~clk;

    bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .fetch_request_enable(fetch_request_enable), .freq_mode(freq_mode),
        .freq_addr(freq_addr), .freq_wdata(freq_wdata), .freq_wstrb(freq_wstrb),
        .fetch_response_enable(fetch_response_enable), .fresp_data(fresp_data),
        .mem_request_enable(mem_request_enable), .mreq_mode(mreq_mode),
        .mreq_addr(mreq_addr), .mreq_wdata(mreq_wdata), .mreq_wstrb(mreq_wstrb),
        .mem_response_enable(mem_response_enable), .mresp_data(mresp_data),
        .bus_request_enable(bus_request_enable), .breq_mode(breq_mode),
        .breq_addr(breq_addr), .breq_wdata(breq_wdata), .breq_wstrb(breq_wstrb),
        .bus_response_enable(bus_response_enable), .bresp_data(bresp_data),
        .busy(busy), .grant_owner(grant_owner), .protocol_err(protocol_err)
    );

    int checks = 0;
    int errors = 0;
    int since_issue = 0;
    logic grant_log[$];

    bit               ref_pend[2];
    logic [REQ_W-1:0] ref_slot[2];
    bit               ref_busy;
    int               ref_owner, ref_last;
    bit               e_breq_en, e_err;
    bit               e_resp_en[2];
    logic [REQ_W-1:0] e_breq;
    logic [DATA_W-1:0] e_rdata[2];

    task automatic checkOutput(input string tag, input logic [159:0] observed,
                               input logic [159:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [159:0] all_outputs();
        return 160'({bus_request_enable, breq_mode, breq_addr, breq_wdata, breq_wstrb,
                     fetch_response_enable, fresp_data, mem_response_enable, mresp_data,
                     busy, grant_owner, protocol_err});
    endfunction

    task automatic ref_reset();
        ref_pend[0] = 0; ref_pend[1] = 0;
        ref_slot[0] = '0; ref_slot[1] = '0;
        ref_busy = 0; ref_owner = 0; ref_last = 1;
        e_breq_en = 0; e_err = 0; e_breq = '0;
        e_resp_en[0] = 0; e_resp_en[1] = 0;
        e_rdata[0] = '0; e_rdata[1] = '0;
        since_issue = 0;
    endtask

    // Reference: accept offers into slots first, then pick from the slots.
    task automatic ref_step();
        bit               req[2];
        bit               offer[2];
        logic [REQ_W-1:0] incoming[2];
        int               win;
        req[0] = fetch_request_enable;
        req[1] = mem_request_enable;
        incoming[0] = {freq_mode, freq_addr, freq_wdata, freq_wstrb};
        incoming[1] = {mreq_mode, mreq_addr, mreq_wdata, mreq_wstrb};
        e_breq_en = 0; e_resp_en[0] = 0; e_resp_en[1] = 0;
        for (int r = 0; r < 2; r++) begin
            offer[r] = 0;
            if (req[r]) begin
                if (ref_pend[r] || (ref_busy && ref_owner == r)) e_err = 1;
                else offer[r] = 1;
            end
        end
        for (int r = 0; r < 2; r++)
            if (offer[r]) begin
                ref_pend[r] = 1;
                ref_slot[r] = incoming[r];
            end
        if (ref_busy) begin
            if (bus_response_enable) begin
                e_resp_en[ref_owner] = 1;
                e_rdata[ref_owner]   = bresp_data;
                ref_busy = 0;
            end
        end else begin
            if (bus_response_enable) e_err = 1;
            win = -1;
            if (ref_pend[0] && ref_pend[1]) win = 1 - ref_last;
            else if (ref_pend[0])           win = 0;
            else if (ref_pend[1])           win = 1;
            if (win >= 0) begin
                e_breq_en     = 1;
                e_breq        = ref_slot[win];
                ref_pend[win] = 0;
                ref_owner     = win;
                ref_last      = win;
                ref_busy      = 1;
            end
        end
    endtask

    task automatic compare_all();
        checkOutput("breq_en", 160'(bus_request_enable), 160'(e_breq_en));
        checkOutput("breq_fields", 160'({breq_mode, breq_addr, breq_wdata, breq_wstrb}), 160'(e_breq));
        checkOutput("fresp_en", 160'(fetch_response_enable), 160'(e_resp_en[0]));
        checkOutput("mresp_en", 160'(mem_response_enable), 160'(e_resp_en[1]));
        checkOutput("fresp_data", 160'(fresp_data), 160'(e_rdata[0]));
        checkOutput("mresp_data", 160'(mresp_data), 160'(e_rdata[1]));
        checkOutput("busy", 160'(busy), 160'(ref_busy));
        checkOutput("grant_owner", 160'(grant_owner), 160'(ref_owner));
        checkOutput("protocol_err", 160'(protocol_err), 160'(e_err));
    endtask

    // One clock: model consumes current inputs, DUT clocks, outputs compared.
    task automatic applyStimulus();
        ref_step();
        @(posedge clk);
        #1;
        compare_all();
        if (bus_request_enable) grant_log.push_back(grant_owner);
        if (e_breq_en) since_issue = 0;
        else since_issue++;
        fetch_request_enable = 0;
        mem_request_enable   = 0;
        bus_response_enable  = 0;
    endtask

    task automatic step_auto(input int delay);
        if (ref_busy && since_issue >= delay) begin
            bus_response_enable = 1;
            bresp_data          = $urandom;
        end
        applyStimulus();
    endtask

    task automatic set_fetch(input logic mode, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] strb);
        fetch_request_enable = 1;
        freq_mode = mode; freq_addr = addr; freq_wdata = wdata; freq_wstrb = strb;
    endtask

    task automatic set_mem(input logic mode, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb);
        mem_request_enable = 1;
        mreq_mode = mode; mreq_addr = addr; mreq_wdata = wdata; mreq_wstrb = strb;
    endtask

    task automatic reset_dut();
        rst = 1;
        fetch_request_enable = 0; mem_request_enable = 0; bus_response_enable = 0;
        #2;
        checkOutput("reset_outputs", all_outputs(), 160'd0);
        ref_reset();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic drain();
        for (int c = 0; c < 40 && (ref_busy || ref_pend[0] || ref_pend[1]); c++)
            step_auto(1);
        checkOutput("drain_idle", 160'(busy), 160'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1;
        fetch_request_enable = 0; freq_mode = 0; freq_addr = '0; freq_wdata = '0; freq_wstrb = '0;
        mem_request_enable = 0; mreq_mode = 0; mreq_addr = '0; mreq_wdata = '0; mreq_wstrb = '0;
        bus_response_enable = 0; bresp_data = '0;
        reset_dut();

        $display("[TB] single fetch read");
        set_fetch(1'b0, 32'h1000, 32'h0, 4'hF);
        applyStimulus();
        checkOutput("t1_breq_en", 160'(bus_request_enable), 160'd1);
        checkOutput("t1_breq_addr", 160'(breq_addr), 160'h1000);
        checkOutput("t1_breq_mode", 160'(breq_mode), 160'd0);
        applyStimulus();
        applyStimulus();
        bus_response_enable = 1; bresp_data = 32'hDEADBEEF;
        applyStimulus();
        checkOutput("t1_fresp_en", 160'(fetch_response_enable), 160'd1);
        checkOutput("t1_fresp_data", 160'(fresp_data), 160'hDEADBEEF);
        checkOutput("t1_mresp_en", 160'(mem_response_enable), 160'd0);

        $display("[TB] simultaneous fetch and mem after reset");
        reset_dut();
        set_fetch(1'b0, 32'h1100, 32'h0, 4'hF);
        set_mem(1'b1, 32'h2000, 32'h12345678, 4'b0011);
        applyStimulus();
        checkOutput("t2_first_owner", 160'(grant_owner), 160'd0);
        checkOutput("t2_first_addr", 160'(breq_addr), 160'h1100);
        applyStimulus();
        bus_response_enable = 1; bresp_data = 32'h11111111;
        applyStimulus();
        checkOutput("t2_fresp_en", 160'(fetch_response_enable), 160'd1);
        checkOutput("t2_no_mresp", 160'(mem_response_enable), 160'd0);
        applyStimulus();
        checkOutput("t2_mem_breq_en", 160'(bus_request_enable), 160'd1);
        checkOutput("t2_mem_owner", 160'(grant_owner), 160'd1);
        checkOutput("t2_mem_fields", 160'({breq_mode, breq_addr, breq_wdata, breq_wstrb}),
                    160'({1'b1, 32'h2000, 32'h12345678, 4'b0011}));
        bus_response_enable = 1; bresp_data = 32'h22222222;
        applyStimulus();
        checkOutput("t2_mresp_en", 160'(mem_response_enable), 160'd1);
        checkOutput("t2_mresp_data", 160'(mresp_data), 160'h22222222);
        checkOutput("t2_no_fresp", 160'(fetch_response_enable), 160'd0);

        $display("[TB] continuous requests alternate");
        grant_log.delete();
        for (int c = 0; c < 80 && grant_log.size() < 6; c++) begin
            if (!ref_pend[0] && !(ref_busy && ref_owner == 0))
                set_fetch(1'($urandom), $urandom, $urandom, 4'($urandom));
            if (!ref_pend[1] && !(ref_busy && ref_owner == 1))
                set_mem(1'($urandom), $urandom, $urandom, 4'($urandom));
            step_auto(1);
        end
        checkOutput("t3_grant_count", 160'(grant_log.size()), 160'd6);
        for (int k = 0; k < 6 && k < grant_log.size(); k++)
            checkOutput($sformatf("t3_grant_%0d", k), 160'(grant_log[k]), 160'(k % 2));
        drain();

        $display("[TB] mem write during fetch wait");
        set_fetch(1'b0, 32'h1200, 32'h0, 4'hF);
        applyStimulus();
        set_mem(1'b1, 32'h2200, 32'hA5A5A5A5, 4'b1100);
        applyStimulus();
        checkOutput("t4_no_issue", 160'(bus_request_enable), 160'd0);
        applyStimulus();
        bus_response_enable = 1; bresp_data = 32'h33333333;
        applyStimulus();
        checkOutput("t4_busy_gap", 160'(busy), 160'd0);
        checkOutput("t4_gap_no_issue", 160'(bus_request_enable), 160'd0);
        applyStimulus();
        checkOutput("t4_busy_again", 160'(busy), 160'd1);
        checkOutput("t4_mem_issue", 160'(bus_request_enable), 160'd1);
        checkOutput("t4_mem_fields", 160'({breq_mode, breq_addr, breq_wdata, breq_wstrb}),
                    160'({1'b1, 32'h2200, 32'hA5A5A5A5, 4'b1100}));
        drain();

        $display("[TB] protocol violations");
        bus_response_enable = 1; bresp_data = 32'h44444444;
        applyStimulus();
        checkOutput("t5_err_idle_resp", 160'(protocol_err), 160'd1);
        checkOutput("t5_no_resp", 160'({fetch_response_enable, mem_response_enable}), 160'd0);
        set_mem(1'b0, 32'h3000, 32'h0, 4'hF);
        applyStimulus();
        set_fetch(1'b0, 32'h4000, 32'h01020304, 4'b0101);
        applyStimulus();
        set_fetch(1'b1, 32'h5000, 32'hFFFFFFFF, 4'b1111);
        applyStimulus();
        bus_response_enable = 1; bresp_data = 32'h55555555;
        applyStimulus();
        applyStimulus();
        checkOutput("t5_orig_issue", 160'(bus_request_enable), 160'd1);
        checkOutput("t5_orig_fields", 160'({breq_mode, breq_addr, breq_wdata, breq_wstrb}),
                    160'({1'b0, 32'h4000, 32'h01020304, 4'b0101}));
        checkOutput("t5_err_sticky", 160'(protocol_err), 160'd1);
        drain();

        $display("[TB] reset during wait");
        set_fetch(1'b0, 32'h1300, 32'h0, 4'hF);
        applyStimulus();
        applyStimulus();
        reset_dut();
        bus_response_enable = 1; bresp_data = 32'h66666666;
        applyStimulus();
        checkOutput("t6_err_after_reset", 160'(protocol_err), 160'd1);
        set_fetch(1'b0, 32'h6000, 32'h0, 4'hF);
        applyStimulus();
        checkOutput("t6_issue", 160'(bus_request_enable), 160'd1);
        bus_response_enable = 1; bresp_data = 32'hCAFEF00D;
        applyStimulus();
        checkOutput("t6_fresp_en", 160'(fetch_response_enable), 160'd1);
        checkOutput("t6_fresp_data", 160'(fresp_data), 160'hCAFEF00D);

        $display("[TB] random traffic");
        reset_dut();
        for (int c = 0; c < 300; c++) begin
            if ($urandom_range(0, 3) == 0)
                set_fetch(1'($urandom), $urandom, $urandom, 4'($urandom));
            if ($urandom_range(0, 3) == 0)
                set_mem(1'($urandom), $urandom, $urandom, 4'($urandom));
            if (!ref_busy && $urandom_range(0, 59) == 0) begin
                bus_response_enable = 1;
                bresp_data          = $urandom;
            end
            step_auto(int'($urandom_range(0, 4)));
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-requester, single-outstanding arbiter that shares one memory/bus port between the core's instruction-fetch and data-memory request interfaces.
- Sits between the core's fetch/mem request ports and the downstream MMU/bus port.
- Captures one-cycle request pulses and grants them round-robin.
- Routes each bus response back to the requester that owns the outstanding transaction.

Parameters:
- ADDR_W, 32, request address width
- DATA_W, 32, write/read data width; wstrb width is DATA_W/8

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- fetch_request_enable  in  1  one-cycle fetch request pulse
- freq_mode  in  1  0=read, 1=write
- freq_addr  in  ADDR_W  fetch address
- freq_wdata  in  DATA_W  fetch write data
- freq_wstrb  in  DATA_W/8  fetch byte strobes
- fetch_response_enable  out  1  one-cycle fetch response pulse
- fresp_data  out  DATA_W  fetch response data
- mem_request_enable, mreq_mode, mreq_addr, mreq_wdata, mreq_wstrb  in  1/1/ADDR_W/DATA_W/DATA_W/8  data-side request, same semantics as fetch
- mem_response_enable  out  1  data-side response pulse
- mresp_data  out  DATA_W  data-side response data
- bus_request_enable  out  1  one-cycle downstream request pulse
- breq_mode, breq_addr, breq_wdata, breq_wstrb  out  1/ADDR_W/DATA_W/DATA_W/8  downstream request fields
- bus_response_enable  in  1  one-cycle downstream response pulse
- bresp_data  in  DATA_W  downstream response data
- busy  out  1  a transaction is outstanding downstream
- grant_owner  out  1  owner of current/last grant; 0=fetch, 1=mem
- protocol_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (asynchronous, rst=1): all outputs 0, all fields 0, state IDLE, pending flags cleared. last_grant=1 (mem), so the first tie goes to fetch.
- Per requester, a pending slot holds {mode, addr, wdata, wstrb}. A request pulse loads the slot at the clock edge unless it is granted directly in the same cycle (bypass).
- A request pulse while that requester's slot is already pending, or while that requester owns the outstanding transaction, is dropped and sets protocol_err. The stored request is unchanged.
- Candidates in IDLE: pending slot OR incoming pulse, per requester.
- Arbitration in IDLE:
  - If exactly one candidate, grant it.
  - If both are candidates, grant the requester that is not last_grant.
  - On a grant: at the edge, bus_request_enable=1 for exactly one cycle, breq_* = granted fields, grant_owner=winner, last_grant=winner. The winner's slot is cleared; the loser's slot is loaded or kept. State goes to WAIT.
- Latency: request pulse in cycle N with the arbiter IDLE and no competitor -> bus_request_enable high in cycle N+1.
- breq_* hold their values until the next grant.
- WAIT state:
  - busy=1.
  - New request pulses are only captured into slots; nothing is issued downstream.
  - On bus_response_enable: at the edge, the owner's response_enable=1 for one cycle and its data register = bresp_data. The other requester's response signals stay 0. State returns to IDLE and busy=0.
- The next grant is evaluated in the cycle after the response is forwarded. Response in cycle M -> owner pulse in M+1 -> next bus_request_enable at earliest M+2.
- bus_response_enable while IDLE is ignored and sets protocol_err.
- Response data registers hold their values between responses.
- protocol_err clears only on reset.
- Reset mid-transaction: the transaction is abandoned. A later bus_response_enable while IDLE is flagged as protocol_err.
- No timeout; WAIT lasts indefinitely until a response arrives.

Test Plan:
- Single fetch read, addr 0x1000, with a bus response 3 cycles later carrying 0xDEADBEEF -> bus_request_enable at N+1 with breq_addr=0x1000, mode 0. fetch_response_enable one cycle after the bus response with fresp_data=0xDEADBEEF. mem_response_enable stays 0.
- Fetch and mem pulses in the same cycle right after reset -> fetch granted first. Mem granted at response+2 with its latched addr/wdata/wstrb (e.g. 0x2000, 0x12345678, 4'b0011). Responses routed to the correct sides.
- Both requesters continuously re-request for 6 transactions -> grants alternate F,M,F,M,F,M. No requester is starved.
- Mem write pulse while a fetch is in WAIT -> no downstream pulse until the fetch response is forwarded. Mem request issued at M+2 with unchanged fields. busy deasserts for exactly one cycle between the two transactions.
- bus_response_enable while IDLE, and a second fetch pulse while a fetch is pending -> protocol_err=1 and stays 1. No response pulses generated. The original pending request is issued unaltered.
- Assert rst during WAIT -> all outputs 0 immediately. A subsequent bus response sets protocol_err. A new fetch request after reset completes normally.
